// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int DATA_WIDTH_DFLT = 32;
  localparam int BYTE_LANES      = DATA_WIDTH_DFLT / 8;

  // A request is in error when it is not word aligned or its word index lies past the storage.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the Memory stage and the responder.
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_we_i;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic [DATA_WIDTH-1:0]   req_wdata_i;
  logic [DATA_WIDTH/8-1:0] req_be_i;
  logic                    resp_valid_o;
  logic                    resp_ready_i;
  logic [DATA_WIDTH-1:0]   resp_rdata_o;
  logic                    resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: byte-enabled synchronous write, synchronous read of the same index.
// Not reset; contents survive a responder reset.
module dmem_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [IDX_W-1:0]        widx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Lane-wise write and registered read; a read in the same cycle sees the old word.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DATA_WIDTH / 8; k++) begin
      if (we_i && be_i[k]) begin
        mem[widx_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
      end
    end
    rdata_o <= mem[widx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory responder: one outstanding request, fixed latency, byte-enabled word access.
//
//  state | meaning
//  IDLE  | ready for a request; accept latches the request and loads the latency counter
//  WAIT  | counting down; at zero the access is performed and the response registered
//  RESP  | response held until the initiator takes it
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  dmem_responder_if.slave bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_t           state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      be_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;

  logic                  arr_we;
  logic [IDX_W-1:0]      arr_idx;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign bus.req_ready_o  = (state == IDLE) && rst_i;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.resp_rdata_o = resp_rdata_q;

  // In IDLE the array is pointed at the incoming address so the read word is already
  // registered by the time the counter expires, even with a latency of one.
  assign arr_idx = (state == IDLE) ? bus.req_addr_i[IDX_W+1:2] : idx_q;
  assign arr_we  = (state == WAIT) && (cnt == 4'd0) && we_q && !err_q;

  dmem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .be_i    (be_q),
    .widx_i  (arr_idx),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // Request/response sequencing with the latency down-counter and registered response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            we_q    <= bus.req_we_i;
            idx_q   <= bus.req_addr_i[IDX_W+1:2];
            wdata_q <= bus.req_wdata_i;
            be_q    <= bus.req_be_i;
            err_q   <= addr_err(64'(bus.req_addr_i), unsigned'(DEPTH_WORDS));
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            resp_rdata_q <= (!we_q && !err_q) ? arr_rdata : '0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_responder #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem_m [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] addr);
    return ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
  endfunction

  task automatic scramble_req();
    bus.req_valid_i = 1'($urandom);
    bus.req_we_i    = 1'($urandom);
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_be_i    = 4'($urandom);
  endtask

  // One full transaction; request fields are scrambled while the responder is busy.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int hold, input string nm);
    logic        e_err;
    logic [31:0] e_rd;
    logic [31:0] w;
    int          waitc;
    int          lat;
    logic        seen;
    e_err = model_err(addr);
    e_rd  = (!we && !e_err) ? mem_m[addr / 4] : 32'h0;

    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wd;
    bus.req_be_i    = be;
    waitc = 0;
    while (!bus.req_ready_o && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({nm, "_accept"}, 64'(waitc < 20), 64'(1));
    if (waitc >= 20) begin
      bus.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk({nm, "_busy_ready"}, 64'(bus.req_ready_o), 64'(0));

    seen = 1'b0;
    lat  = 0;
    for (int e = 1; e <= 40 && !seen; e++) begin
      scramble_req();
      @(posedge clk); #1;
      if (bus.resp_valid_o) begin
        seen = 1'b1;
        lat  = e;
      end
    end
    bus.req_valid_i = 1'b0;
    chk({nm, "_resp_seen"}, 64'(seen), 64'(1));
    if (!seen) return;
    chk({nm, "_latency"}, 64'(lat), 64'(LAT));
    chk({nm, "_rdata"}, 64'(bus.resp_rdata_o), 64'(e_rd));
    chk({nm, "_err"}, 64'(bus.resp_err_o), 64'(e_err));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, "_bp_valid"}, 64'(bus.resp_valid_o), 64'(1));
      chk({nm, "_bp_rdata"}, 64'(bus.resp_rdata_o), 64'(e_rd));
      chk({nm, "_bp_err"}, 64'(bus.resp_err_o), 64'(e_err));
      chk({nm, "_bp_ready"}, 64'(bus.req_ready_o), 64'(0));
    end

    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    chk({nm, "_done_valid"}, 64'(bus.resp_valid_o), 64'(0));
    chk({nm, "_done_err"}, 64'(bus.resp_err_o), 64'(0));
    chk({nm, "_done_ready"}, 64'(bus.req_ready_o), 64'(1));

    if (we && !e_err) begin
      w = mem_m[addr / 4];
      for (int k = 0; k < 4; k++) begin
        if (be[k]) w[k*8 +: 8] = wd[k*8 +: 8];
      end
      mem_m[addr / 4] = w;
    end
  endtask

  function automatic int pick_idx();
    int r;
    r = int'($urandom_range(0, 19));
    return (r < 16) ? r : 1004 + r;
  endfunction

  initial begin
    logic [31:0] a;
    int          idx;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.req_be_i     = '0;
    bus.resp_ready_i = 1'b0;

    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'(0));
    chk("rst_valid", 64'(bus.resp_valid_o), 64'(0));
    chk("rst_err", 64'(bus.resp_err_o), 64'(0));
    chk("rst_rdata", 64'(bus.resp_rdata_o), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_ready", 64'(bus.req_ready_o), 64'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_no_resp", 64'(bus.resp_valid_o), 64'(0));
    end

    // Give the model a defined window of storage.
    for (int i = 0; i < 20; i++) begin
      idx = (i < 16) ? i : 1004 + i;
      run_txn(1'b1, 32'(idx * 4), $urandom, 4'hF, 0, "init");
    end

    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr10");
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd10");
    run_txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, "wr10_be");
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd10_be");
    chk("lane_merge_model", 64'(mem_m[4]), 64'(32'hDE22BE44));
    run_txn(1'b1, 32'h14, 32'hCAFEF00D, 4'h0, 0, "wr_be0");
    run_txn(1'b0, 32'h14, 32'h0, 4'h0, 0, "rd_be0");
    run_txn(1'b0, 32'h13, 32'h0, 4'h0, 0, "rd_misal");
    run_txn(1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 0, "wr_oor");
    run_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, "rd_alias0");
    run_txn(1'b1, 32'h13, 32'h5A5A5A5A, 4'hF, 0, "wr_misal");
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "rd_after_misal");
    run_txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0, "rd_top");
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, "bp");

    // Reset while the write to 0x20 is still counting down.
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 32'h20;
    bus.req_wdata_i = 32'h12345678;
    bus.req_be_i    = 4'hF;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("wrst_ready", 64'(bus.req_ready_o), 64'(0));
    chk("wrst_valid", 64'(bus.resp_valid_o), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("wrst_no_resp", 64'(bus.resp_valid_o), 64'(0));
    end
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, "rd20_after_rst");

    for (int t = 0; t < 150; t++) begin
      idx = pick_idx();
      case ($urandom_range(0, 9))
        0:       a = 32'(idx * 4) + 32'($urandom_range(1, 3));
        1:       a = ($urandom | 32'h1000) & ~32'h3;
        default: a = 32'(idx * 4);
      endcase
      run_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
